// File: rtl/ahb_matrix_param.sv
// ahb_matrix_param: shared-bus AHB-Lite fabric for NUM_M masters / NUM_S slaves.
// Address phase is muxed from the owning master (hmaster); the data phase is
// tracked by registered dmaster/dslave/dactive. Unmapped regions go to an
// internal default slave that answers with a two-cycle ERROR.
// Build option: define AHB_MATRIX_RR_ARB_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins).
module ahb_matrix_param #(
    parameter int NUM_M = 4,
    parameter int NUM_S = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_M-1:0]    m_HBUSREQ,
    input  logic [NUM_M*AW-1:0] m_HADDR,
    input  logic [2*NUM_M-1:0]  m_HTRANS,
    input  logic [NUM_M-1:0]    m_HWRITE,
    input  logic [3*NUM_M-1:0]  m_HSIZE,
    input  logic [3*NUM_M-1:0]  m_HBURST,
    input  logic [NUM_M*DW-1:0] m_HWDATA,
    output logic [NUM_M-1:0]    m_HGRANT,
    output logic [DW-1:0]       m_HRDATA,
    output logic                m_HREADY,
    output logic [1:0]          m_HRESP,
    output logic [2:0]          hmaster,
    output logic [NUM_S-1:0]    s_HSEL,
    output logic [AW-1:0]       s_HADDR,
    output logic [1:0]          s_HTRANS,
    output logic                s_HWRITE,
    output logic [2:0]          s_HSIZE,
    output logic [2:0]          s_HBURST,
    output logic [DW-1:0]       s_HWDATA,
    output logic                s_HREADYin,
    input  logic [NUM_S*DW-1:0] s_HRDATA,
    input  logic [NUM_S-1:0]    s_HREADY,
    input  logic [2*NUM_S-1:0]  s_HRESP
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    // Slave index NUM_S stands for the internal default slave.
    localparam logic [3:0] DEF_SLV   = 4'(NUM_S);

    typedef struct packed {
        logic          busreq;
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
    } mreq_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          ready;
        logic [1:0]    resp;
    } srsp_t;

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} dstate_t;

    mreq_t [NUM_M-1:0] mreq;
    srsp_t [NUM_S-1:0] srsp;
    mreq_t             own;
    logic [3:0]        region;
    logic [3:0]        aslave;
    logic              locked;
    logic [2:0]        grant_idx;
    logic [2:0]        dmaster;
    logic [3:0]        dslave;
    logic              dactive;
    dstate_t           ds_state, ds_next;
    logic              def_ready;
    logic [1:0]        def_resp;

    // Unpack the flat buses into per-lane request/response structs.
    for (genvar g = 0; g < NUM_M; g++) begin : g_mreq
        assign mreq[g] = {m_HBUSREQ[g], m_HADDR[g*AW +: AW], m_HTRANS[g*2 +: 2],
                          m_HWRITE[g], m_HSIZE[g*3 +: 3], m_HBURST[g*3 +: 3]};
    end
    for (genvar g = 0; g < NUM_S; g++) begin : g_srsp
        assign srsp[g] = {s_HRDATA[g*DW +: DW], s_HREADY[g], s_HRESP[g*2 +: 2]};
    end

    // Address-phase mux: everything comes from the current owner.
    always_comb begin
        own = '0;
        for (int i = 0; i < NUM_M; i++)
            if (hmaster == 3'(i)) own = mreq[i];
    end

    assign s_HADDR  = own.addr;
    assign s_HTRANS = own.trans;
    assign s_HWRITE = own.write;
    assign s_HSIZE  = own.size;
    assign s_HBURST = own.burst;

    // Top nibble picks the region; regions past NUM_S fall to the default slave.
    assign region = own.addr[AW-1:AW-4];
    assign aslave = (region < DEF_SLV) ? region : DEF_SLV;

    // One-hot select; stays all-zero when the default slave is targeted.
    always_comb begin
        s_HSEL = '0;
        for (int i = 0; i < NUM_S; i++) s_HSEL[i] = (aslave == 4'(i));
    end

    // Write data belongs to the data-phase owner.
    always_comb begin
        s_HWDATA = '0;
        for (int i = 0; i < NUM_M; i++)
            if (dmaster == 3'(i)) s_HWDATA = m_HWDATA[i*DW +: DW];
    end

    // Owner keeps the bus through bursts and while it is mid-transfer.
    assign locked = own.busreq &&
                    (own.trans == TR_SEQ || own.trans == TR_BUSY ||
                     (own.trans == TR_NONSEQ && own.burst != BU_SINGLE));

`ifdef AHB_MATRIX_RR_ARB_EN
    logic [2:0] last;

    // Remember the most recent handover target so the search rotates.
    always_ff @(posedge HCLK) begin
        if (HRESET)                             last <= 3'd0;
        else if (m_HREADY && grant_idx != hmaster) last <= grant_idx;
    end
`endif

    // Arbiter: hold during wait states or lock, else pick a requester (default master 0).
    always_comb begin
        logic found;
        found     = 1'b0;
        grant_idx = 3'd0;
        if (!m_HREADY || locked) begin
            grant_idx = hmaster;
        end else begin
`ifdef AHB_MATRIX_RR_ARB_EN
            for (int k = 1; k <= NUM_M; k++)
                for (int i = 0; i < NUM_M; i++)
                    if (!found && m_HBUSREQ[i] && i == (int'(last) + k) % NUM_M) begin
                        grant_idx = 3'(i);
                        found     = 1'b1;
                    end
`else
            for (int i = 0; i < NUM_M; i++)
                if (!found && m_HBUSREQ[i]) begin
                    grant_idx = 3'(i);
                    found     = 1'b1;
                end
`endif
        end
    end

    // Grant output is the one-hot of the next owner.
    always_comb begin
        m_HGRANT = '0;
        for (int i = 0; i < NUM_M; i++) m_HGRANT[i] = (grant_idx == 3'(i));
    end

    // Address and data phase ownership advance together on HREADY.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hmaster <= 3'd0;
            dmaster <= 3'd0;
            dslave  <= DEF_SLV;
            dactive <= 1'b0;
        end else if (m_HREADY) begin
            hmaster <= grant_idx;
            dmaster <= hmaster;
            dslave  <= aslave;
            dactive <= own.trans[1];
        end
    end

    // Default slave state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) ds_state <= DS_IDLE;
        else        ds_state <= ds_next;
    end

    // Default slave next state: an accepted active transfer to it starts ERROR.
    always_comb begin
        ds_next = DS_IDLE;
        case (ds_state)
            DS_ERR1: ds_next = DS_ERR2;
            default: ds_next = (m_HREADY && aslave == DEF_SLV && own.trans[1])
                               ? DS_ERR1 : DS_IDLE;
        endcase
    end

    // Outputs decode from state only, keeping HREADY out of a combinational loop.
    assign def_ready = (ds_state != DS_ERR1);
    assign def_resp  = (ds_state == DS_IDLE) ? RSP_OKAY : RSP_ERROR;

    // Response mux from the data-phase slave; idle data phase is zero-wait OKAY.
    always_comb begin
        m_HREADY = 1'b1;
        m_HRESP  = RSP_OKAY;
        m_HRDATA = '0;
        if (dactive) begin
            if (dslave == DEF_SLV) begin
                m_HREADY = def_ready;
                m_HRESP  = def_resp;
            end else begin
                for (int i = 0; i < NUM_S; i++)
                    if (dslave == 4'(i)) begin
                        m_HREADY = srsp[i].ready;
                        m_HRESP  = srsp[i].resp;
                        m_HRDATA = srsp[i].rdata;
                    end
            end
        end
    end

    assign s_HREADYin = m_HREADY;

    // Idle-state tie-off: TR_IDLE is kept for readability of the encoding set.
    logic unused_ok;
    assign unused_ok = ^TR_IDLE;

endmodule

// File: tb/tb_ahb_matrix_param.sv
// Directed bench for ahb_matrix_param (NUM_M=4, NUM_S=4, 32-bit).
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after.
module tb_ahb_matrix_param;
    localparam int NUM_M = 4;
    localparam int NUM_S = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;

    logic                HCLK = 1'b0;
    logic                HRESET;
    logic [NUM_M-1:0]    m_HBUSREQ;
    logic [NUM_M*AW-1:0] m_HADDR;
    logic [2*NUM_M-1:0]  m_HTRANS;
    logic [NUM_M-1:0]    m_HWRITE;
    logic [3*NUM_M-1:0]  m_HSIZE;
    logic [3*NUM_M-1:0]  m_HBURST;
    logic [NUM_M*DW-1:0] m_HWDATA;
    logic [NUM_M-1:0]    m_HGRANT;
    logic [DW-1:0]       m_HRDATA;
    logic                m_HREADY;
    logic [1:0]          m_HRESP;
    logic [2:0]          hmaster;
    logic [NUM_S-1:0]    s_HSEL;
    logic [AW-1:0]       s_HADDR;
    logic [1:0]          s_HTRANS;
    logic                s_HWRITE;
    logic [2:0]          s_HSIZE;
    logic [2:0]          s_HBURST;
    logic [DW-1:0]       s_HWDATA;
    logic                s_HREADYin;
    logic [NUM_S*DW-1:0] s_HRDATA;
    logic [NUM_S-1:0]    s_HREADY;
    logic [2*NUM_S-1:0]  s_HRESP;

    int vec  = 0;
    int errs = 0;

    ahb_matrix_param #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .m_HBUSREQ(m_HBUSREQ), .m_HADDR(m_HADDR), .m_HTRANS(m_HTRANS),
        .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST),
        .m_HWDATA(m_HWDATA), .m_HGRANT(m_HGRANT), .m_HRDATA(m_HRDATA),
        .m_HREADY(m_HREADY), .m_HRESP(m_HRESP), .hmaster(hmaster),
        .s_HSEL(s_HSEL), .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS),
        .s_HWRITE(s_HWRITE), .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST),
        .s_HWDATA(s_HWDATA), .s_HREADYin(s_HREADYin),
        .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_m(input int i, input logic req, input logic [AW-1:0] addr,
                           input logic [1:0] trans, input logic wr, input logic [2:0] burst);
        m_HBUSREQ[i]         = req;
        m_HADDR[i*AW +: AW]  = addr;
        m_HTRANS[i*2 +: 2]   = trans;
        m_HWRITE[i]          = wr;
        m_HSIZE[i*3 +: 3]    = 3'b010;
        m_HBURST[i*3 +: 3]   = burst;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NUM_M; i++) drive_m(i, 1'b0, '0, IDLE, 1'b0, SINGLE);
        m_HWDATA = '0;
        for (int i = 0; i < NUM_S; i++) s_HRDATA[i*DW +: DW] = 32'h5100_0000 + 32'(i);
        s_HREADY = '1;
        s_HRESP  = '0;
    endtask

    task automatic test_reset();
        idle_all();
        HRESET = 1'b1;
        step(); step();
        HRESET = 1'b0;
        #1;
        vec++; if (hmaster !== 3'd0) begin errs++; $display("FAIL reset_hmaster got %0d exp 0", hmaster); end
        vec++; if (m_HGRANT !== 4'b0001) begin errs++; $display("FAIL reset_grant got %b exp 0001", m_HGRANT); end
        vec++; if (m_HREADY !== 1'b1) begin errs++; $display("FAIL reset_hready got %b exp 1", m_HREADY); end
        vec++; if (m_HRESP !== 2'b00) begin errs++; $display("FAIL reset_hresp got %b exp 00", m_HRESP); end
        vec++; if (m_HRDATA !== 32'h0) begin errs++; $display("FAIL reset_hrdata got %h exp 0", m_HRDATA); end
        vec++; if (s_HSEL !== 4'b0001) begin errs++; $display("FAIL reset_hsel got %b exp 0001", s_HSEL); end
    endtask

    task automatic test_write();
        idle_all();
        step();
        drive_m(1, 1'b1, 32'h0, IDLE, 1'b0, SINGLE);
        #1;
        vec++; if (m_HGRANT !== 4'b0010) begin errs++; $display("FAIL wr_grant got %b exp 0010", m_HGRANT); end
        step();
        drive_m(1, 1'b0, 32'h1000_0004, NONSEQ, 1'b1, SINGLE);
        #1;
        vec++; if (hmaster !== 3'd1) begin errs++; $display("FAIL wr_hmaster got %0d exp 1", hmaster); end
        vec++; if (s_HADDR !== 32'h1000_0004) begin errs++; $display("FAIL wr_haddr got %h exp 10000004", s_HADDR); end
        vec++; if (s_HSEL !== 4'b0010) begin errs++; $display("FAIL wr_hsel got %b exp 0010", s_HSEL); end
        vec++; if (s_HWRITE !== 1'b1) begin errs++; $display("FAIL wr_hwrite got %b exp 1", s_HWRITE); end
        step();
        m_HWDATA[0*DW +: DW] = 32'h1111_1111;
        m_HWDATA[1*DW +: DW] = 32'hDEAD_BEEF;
        drive_m(1, 1'b0, 32'h0, IDLE, 1'b0, SINGLE);
        #1;
        vec++; if (s_HWDATA !== 32'hDEAD_BEEF) begin errs++; $display("FAIL wr_hwdata got %h exp deadbeef", s_HWDATA); end
        vec++; if (m_HRESP !== 2'b00) begin errs++; $display("FAIL wr_hresp got %b exp 00", m_HRESP); end
        vec++; if (m_HREADY !== 1'b1) begin errs++; $display("FAIL wr_hready got %b exp 1", m_HREADY); end
    endtask

    task automatic test_default_slave();
        idle_all();
        step();
        drive_m(0, 1'b0, 32'hF000_0000, NONSEQ, 1'b0, SINGLE);
        #1;
        vec++; if (s_HSEL !== 4'b0000) begin errs++; $display("FAIL dflt_hsel got %b exp 0000", s_HSEL); end
        step();
        drive_m(0, 1'b0, 32'hF000_0000, IDLE, 1'b0, SINGLE);
        #1;
        vec++; if (m_HREADY !== 1'b0) begin errs++; $display("FAIL dflt_c1_hready got %b exp 0", m_HREADY); end
        vec++; if (m_HRESP !== 2'b01) begin errs++; $display("FAIL dflt_c1_hresp got %b exp 01", m_HRESP); end
        step();
        #1;
        vec++; if (m_HREADY !== 1'b1) begin errs++; $display("FAIL dflt_c2_hready got %b exp 1", m_HREADY); end
        vec++; if (m_HRESP !== 2'b01) begin errs++; $display("FAIL dflt_c2_hresp got %b exp 01", m_HRESP); end
        step();
        #1;
        vec++; if (m_HRESP !== 2'b00) begin errs++; $display("FAIL dflt_after_hresp got %b exp 00", m_HRESP); end
    endtask

    task automatic test_burst();
        idle_all();
        step();
        drive_m(2, 1'b1, 32'h0, IDLE, 1'b0, SINGLE);
        drive_m(3, 1'b1, 32'h0, IDLE, 1'b0, SINGLE);
        #1;
        vec++; if (m_HGRANT !== 4'b0100) begin errs++; $display("FAIL bst_grant0 got %b exp 0100", m_HGRANT); end
        step();
        drive_m(2, 1'b1, 32'h2000_0000, NONSEQ, 1'b1, INCR4);
        #1;
        vec++; if (hmaster !== 3'd2) begin errs++; $display("FAIL bst_b1_hmaster got %0d exp 2", hmaster); end
        vec++; if (m_HGRANT !== 4'b0100) begin errs++; $display("FAIL bst_b1_grant got %b exp 0100", m_HGRANT); end
        vec++; if (s_HSEL !== 4'b0100) begin errs++; $display("FAIL bst_b1_hsel got %b exp 0100", s_HSEL); end
        step();
        for (int b = 1; b <= 2; b++) begin
            drive_m(2, 1'b1, 32'h2000_0000 + 32'(4*b), SEQ, 1'b1, INCR4);
            #1;
            vec++; if (m_HGRANT !== 4'b0100) begin errs++; $display("FAIL bst_b%0d_grant got %b exp 0100", b+1, m_HGRANT); end
            vec++; if (hmaster !== 3'd2) begin errs++; $display("FAIL bst_b%0d_hmaster got %0d exp 2", b+1, hmaster); end
            step();
        end
        drive_m(2, 1'b0, 32'h2000_000C, SEQ, 1'b1, INCR4);
        #1;
        vec++; if (hmaster !== 3'd2) begin errs++; $display("FAIL bst_b4_hmaster got %0d exp 2", hmaster); end
        vec++; if (m_HGRANT !== 4'b1000) begin errs++; $display("FAIL bst_b4_grant got %b exp 1000", m_HGRANT); end
        step();
        drive_m(2, 1'b0, 32'h0, IDLE, 1'b0, SINGLE);
        #1;
        vec++; if (hmaster !== 3'd3) begin errs++; $display("FAIL bst_handover got %0d exp 3", hmaster); end
    endtask

    task automatic test_arbitration();
        int exp_seq [5];
        logic [3:0] oh;
`ifdef AHB_MATRIX_RR_ARB_EN
        exp_seq = '{1, 2, 3, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        idle_all();
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        for (int i = 0; i < NUM_M; i++) drive_m(i, 1'b1, 32'h0, IDLE, 1'b0, SINGLE);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << exp_seq[k];
            #1;
            vec++; if (m_HGRANT !== oh) begin errs++; $display("FAIL arb_grant%0d got %b exp %b", k, m_HGRANT, oh); end
            step();
            vec++; if (hmaster !== 3'(exp_seq[k])) begin errs++; $display("FAIL arb_hmaster%0d got %0d exp %0d", k, hmaster, exp_seq[k]); end
        end
    endtask

    task automatic test_wait_states();
        idle_all();
        step();
        drive_m(0, 1'b0, 32'h2000_0010, NONSEQ, 1'b0, SINGLE);
        #1;
        vec++; if (s_HSEL !== 4'b0100) begin errs++; $display("FAIL ws_hsel got %b exp 0100", s_HSEL); end
        vec++; if (hmaster !== 3'd0) begin errs++; $display("FAIL ws_hmaster0 got %0d exp 0", hmaster); end
        step();
        s_HREADY[2] = 1'b0;
        drive_m(0, 1'b0, 32'h3000_0000, IDLE, 1'b0, SINGLE);
        drive_m(1, 1'b1, 32'h1000_0000, IDLE, 1'b0, SINGLE);
        for (int w = 0; w < 3; w++) begin
            #1;
            vec++; if (m_HREADY !== 1'b0) begin errs++; $display("FAIL ws%0d_hready got %b exp 0", w, m_HREADY); end
            vec++; if (hmaster !== 3'd0) begin errs++; $display("FAIL ws%0d_hmaster got %0d exp 0", w, hmaster); end
            vec++; if (m_HGRANT !== 4'b0001) begin errs++; $display("FAIL ws%0d_grant got %b exp 0001", w, m_HGRANT); end
            vec++; if (s_HADDR !== 32'h3000_0000) begin errs++; $display("FAIL ws%0d_haddr got %h exp 30000000", w, s_HADDR); end
            step();
        end
        s_HREADY[2] = 1'b1;
        s_HRDATA[2*DW +: DW] = 32'hCAFE_F00D;
        #1;
        vec++; if (m_HREADY !== 1'b1) begin errs++; $display("FAIL ws_done_hready got %b exp 1", m_HREADY); end
        vec++; if (m_HRDATA !== 32'hCAFE_F00D) begin errs++; $display("FAIL ws_done_hrdata got %h exp cafef00d", m_HRDATA); end
        vec++; if (m_HGRANT !== 4'b0010) begin errs++; $display("FAIL ws_done_grant got %b exp 0010", m_HGRANT); end
        step();
        vec++; if (hmaster !== 3'd1) begin errs++; $display("FAIL ws_handover got %0d exp 1", hmaster); end
    endtask

    task automatic test_reset_mid_error();
        idle_all();
        step();
        drive_m(0, 1'b0, 32'hF000_0000, NONSEQ, 1'b0, SINGLE);
        #1;
        vec++; if (hmaster !== 3'd0) begin errs++; $display("FAIL rst_err_hmaster got %0d exp 0", hmaster); end
        step();
        drive_m(0, 1'b0, 32'hF000_0000, IDLE, 1'b0, SINGLE);
        #1;
        vec++; if (m_HREADY !== 1'b0) begin errs++; $display("FAIL rst_err_c1_hready got %b exp 0", m_HREADY); end
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        #1;
        vec++; if (m_HREADY !== 1'b1) begin errs++; $display("FAIL rst_err_hready got %b exp 1", m_HREADY); end
        vec++; if (m_HRESP !== 2'b00) begin errs++; $display("FAIL rst_err_hresp got %b exp 00", m_HRESP); end
        vec++; if (m_HGRANT !== 4'b0001) begin errs++; $display("FAIL rst_err_grant got %b exp 0001", m_HGRANT); end
        vec++; if (m_HRDATA !== 32'h0) begin errs++; $display("FAIL rst_err_hrdata got %h exp 0", m_HRDATA); end
        step();
        #1;
        vec++; if (m_HRESP !== 2'b00) begin errs++; $display("FAIL rst_err_after_hresp got %b exp 00", m_HRESP); end
        vec++; if (m_HREADY !== 1'b1) begin errs++; $display("FAIL rst_err_after_hready got %b exp 1", m_HREADY); end
    endtask

    initial begin
        HRESET    = 1'b1;
        m_HBUSREQ = '0; m_HADDR = '0; m_HTRANS = '0; m_HWRITE = '0;
        m_HSIZE   = '0; m_HBURST = '0; m_HWDATA = '0;
        s_HRDATA  = '0; s_HREADY = '1; s_HRESP = '0;
        test_reset();
        test_write();
        test_default_slave();
        test_burst();
        test_arbitration();
        test_wait_states();
        test_reset_mid_error();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/ahb_matrix_param.md
# ahb_matrix_param

Parametrised successor to the fixed five-master/five-slave AHB fabric. It provides a shared-bus AHB-Lite interconnect for NUM_M masters and NUM_S slaves, with registered address-to-data phase tracking and a burst-aware arbiter. A built-in default slave returns ERROR for unmapped addresses. It sits between the NN calculator masters (CPU, DMA, testbench) and the memory-mapped slaves, replacing the hard-wired fabric.

## Interface
- NUM_M, 4, number of masters (2..8)
- NUM_S, 4, number of mapped slaves (1..15)
- AW, 32, address width
- DW, 32, data width
- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- m_HBUSREQ  in  NUM_M  per-master bus request
- m_HADDR  in  NUM_M*AW  packed master addresses, master i at [i*AW +: AW]
- m_HTRANS  in  2*NUM_M  packed HTRANS
- m_HWRITE  in  NUM_M  per-master HWRITE
- m_HSIZE, m_HBURST  in  3*NUM_M each  packed HSIZE / HBURST
- m_HWDATA  in  NUM_M*DW  packed write data
- m_HGRANT  out  NUM_M  one-hot grant
- m_HRDATA  out  DW  read data broadcast to masters
- m_HREADY  out  1  HREADY broadcast to masters
- m_HRESP  out  2  HRESP broadcast to masters
- hmaster  out  3  index of address-phase owner
- s_HSEL  out  NUM_S  one-hot slave select
- s_HADDR  out  AW; s_HTRANS 2; s_HWRITE 1; s_HSIZE 3; s_HBURST 3  muxed address-phase signals
- s_HWDATA  out  DW  muxed write data
- s_HREADYin  out  1  equals m_HREADY
- s_HRDATA  in  NUM_S*DW; s_HREADY  in  NUM_S; s_HRESP  in  2*NUM_S  per-slave responses

## Operation
- Address decode: region = HADDR[AW-1:AW-4]. Region r < NUM_S selects slave r. Any other region selects the internal default slave, and s_HSEL is all-zero.
- Address mux: s_HADDR/HTRANS/HWRITE/HSIZE/HBURST are combinational from master `hmaster`.
- Data-phase registers:
  - `dmaster` and `dslave` (slave index or DEFAULT) load `hmaster` and the decoded target when HREADY=1.
  - `dactive` loads (HTRANS is NONSEQ or SEQ).
- Data muxes:
  - s_HWDATA comes from master `dmaster`.
  - m_HRDATA/HREADY/HRESP come from `dslave`.
  - When `dactive`=0, outputs are HREADY=1, HRESP=OKAY, HRDATA=0.
- Default slave:
  - NONSEQ/SEQ drives a two-cycle ERROR: cycle 1 HREADY=0/HRESP=ERROR(01), cycle 2 HREADY=1/HRESP=ERROR.
  - IDLE/BUSY gets zero-wait OKAY.
- Arbiter, grant computed combinationally:
  - Lock condition: owner's HBUSREQ=1 and owner's HTRANS is SEQ, BUSY, or NONSEQ with HBURST≠SINGLE. While locked, the grant holds on the owner.
  - Otherwise the grant goes to the winning requester (see Configuration).
  - With no requests, master 0 is the default master.
- `hmaster` loads the granted index only when HREADY=1. m_HGRANT is the one-hot of the next owner.
- A master is not retracted mid-burst by the fabric. An undefined-length INCR burst ends when the owner drops HBUSREQ.

## Timing
- Reset values:
  - hmaster=0, dmaster=0, dslave=DEFAULT, dactive=0, default-slave state=IDLE.
  - m_HGRANT=1 (master 0), m_HREADY=1, m_HRESP=OKAY, m_HRDATA=0.
  - s_HSEL follows master 0's address.
- Handover: a request in cycle N with HREADY=1 makes the new master's address appear on s_HADDR in cycle N+1. Its data phase is cycle N+2 at the earliest.
- Address-to-data latency: one HREADY=1 edge. Wait states (HREADY=0) freeze hmaster, dmaster, dslave and the grant.
- Simultaneous events:
  - A handover and a data-phase wait state in the same cycle: the handover is deferred until HREADY=1.
  - A request from the current owner while unlocked still goes through arbitration.
- Reset mid-transfer: all state returns to reset values on the next edge and any default-slave ERROR sequence is aborted. Slaves are not informed.

## Configuration
- Macro AHB_MATRIX_RR_ARB_EN selects the arbitration policy.
- Defined: round-robin. A `last` register (reset 0) updates on each handover, and search starts at last+1 modulo NUM_M.
- Undefined: fixed priority, lowest index wins, and no `last` register is instantiated.
- Lock rules and default-master behaviour are identical in both builds.

## Test plan
- Single master 1 write to 0x1000_0004, data 0xDEAD_BEEF -> s_HSEL=0010, slave 1 sees HWDATA=0xDEAD_BEEF one cycle after the address phase, m_HRESP=OKAY.
- Master 0 NONSEQ read of 0xF000_0000 with NUM_S=4 -> s_HSEL=0000, m_HREADY 0 then 1, with HRESP=ERROR on both cycles.
- Master 2 INCR4 burst while master 3 requests -> grant stays on 2 for all 4 beats and moves to 3 on the first HREADY=1 after the last beat.
- All four masters request continuously, RR build -> grant sequence 1,2,3,0,1…; fixed build -> master 0 held.
- Slave 2 inserts 3 wait states on a read -> hmaster, grant and s_HADDR are frozen for 3 cycles, and m_HRDATA is valid on the HREADY=1 cycle.
- HRESET asserted during cycle 1 of a default-slave ERROR -> next cycle m_HREADY=1, m_HRESP=OKAY, m_HGRANT=0001.
